// File: rtl/ebpc_znz_encoder.sv
// EBPC encoder front end: turns a word stream into a bit-packed zero/non-zero
// run-length code (znz), a stream of non-zero values (nz) and one frame-length
// word per frame (num_words).
// Optional build macro EBPC_ZNZ_ENC_STATS_EN adds zero_words_o, the count of
// zero words per frame, valid together with num_words_o.
module ebpc_znz_encoder #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned OUT_W         = 8,
  parameter int unsigned MAX_ZRL_W     = 4,
  parameter int unsigned LOG_MAX_WORDS = 24
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     last_i,
  input  logic                     vld_i,
  output logic                     rdy_o,
  output logic [OUT_W-1:0]         znz_o,
  output logic                     znz_last_o,
  output logic                     znz_vld_o,
  input  logic                     znz_rdy_i,
  output logic [DATA_W-1:0]        nz_o,
  output logic                     nz_vld_o,
  input  logic                     nz_rdy_i,
  output logic [LOG_MAX_WORDS-1:0] num_words_o,
  output logic                     num_words_vld_o,
  input  logic                     num_words_rdy_i
`ifdef EBPC_ZNZ_ENC_STATS_EN
  ,
  output logic [LOG_MAX_WORDS-1:0] zero_words_o
`endif
);

  localparam int unsigned SYM_W = 2 + MAX_ZRL_W;
  localparam int unsigned BUF_W = OUT_W - 1 + SYM_W;
  localparam int unsigned CNT_W = $clog2(BUF_W + 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                   r_state, w_state_nxt;
  logic                     r_en;
  logic                     r_last_loaded;
  logic [BUF_W-1:0]         r_buf;
  logic [CNT_W-1:0]         r_cnt;
  logic [MAX_ZRL_W-1:0]     r_run;
  logic [LOG_MAX_WORDS-1:0] r_wcnt;
  logic [OUT_W-1:0]         r_znz;
  logic                     r_znz_last, r_znz_vld;
  logic [DATA_W-1:0]        r_nz;
  logic                     r_nz_vld;
  logic [LOG_MAX_WORDS-1:0] r_nw;
  logic                     r_nw_vld;

  logic                     w_rdy, w_acc, w_zero, w_full, w_znz_free;
  logic                     w_emit, w_emit_last;
  logic [SYM_W-1:0]         w_sym;
  logic [CNT_W-1:0]         w_sym_len;
  logic [MAX_ZRL_W-1:0]     w_run_nxt, w_run_m1;
  logic [BUF_W-1:0]         w_buf_sh, w_buf_nxt;
  logic [CNT_W-1:0]         w_cnt_sh, w_cnt_nxt;

  assign w_acc      = vld_i & w_rdy;
  assign w_zero     = (data_i == '0);
  assign w_full     = (r_cnt >= CNT_W'(OUT_W));
  assign w_znz_free = !r_znz_vld | znz_rdy_i;
  assign w_run_m1   = r_run - MAX_ZRL_W'(1);

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  // Next state, input ready and znz emit decisions.
  // In FLUSH a full word always goes out first; the closing word carries the
  // remaining (possibly zero) bits, so every frame ends with exactly one last word.
  always_comb begin
    w_state_nxt = r_state;
    w_rdy       = 1'b0;
    w_emit      = 1'b0;
    w_emit_last = 1'b0;
    case (r_state)
      RUN: begin
        w_rdy  = r_en & !w_full & (!r_nz_vld | nz_rdy_i);
        w_emit = w_full & w_znz_free;
        if (w_acc && last_i) w_state_nxt = FLUSH;
      end
      FLUSH: begin
        if (w_full) begin
          w_emit = w_znz_free;
        end else if (!r_last_loaded) begin
          w_emit      = w_znz_free;
          w_emit_last = w_znz_free;
        end else if (w_znz_free && (!r_nw_vld || num_words_rdy_i)) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Symbol generation for the accepted word and run-length bookkeeping
  always_comb begin
    w_sym     = '0;
    w_sym_len = '0;
    w_run_nxt = r_run;
    if (w_acc) begin
      if (w_zero) begin
        if (r_run == '1 || last_i) begin
          w_sym     = {1'b0, r_run, 1'b0};
          w_sym_len = CNT_W'(1 + MAX_ZRL_W);
          w_run_nxt = '0;
        end else begin
          w_run_nxt = r_run + MAX_ZRL_W'(1);
        end
      end else begin
        if (r_run != '0) begin
          w_sym     = {1'b0, w_run_m1, 1'b1};
          w_sym_len = CNT_W'(SYM_W);
        end else begin
          w_sym     = {1'b1, {(SYM_W-1){1'b0}}};
          w_sym_len = CNT_W'(1);
        end
        w_run_nxt = '0;
      end
    end
  end

  // Bit buffer update: drain the top word first, then append below the remaining bits
  always_comb begin
    w_buf_sh  = w_emit ? (r_buf << OUT_W) : r_buf;
    w_cnt_sh  = w_emit_last ? '0 : (w_emit ? (r_cnt - CNT_W'(OUT_W)) : r_cnt);
    w_buf_nxt = w_buf_sh | ((BUF_W'(w_sym) << (BUF_W - SYM_W)) >> w_cnt_sh);
    w_cnt_nxt = w_cnt_sh + w_sym_len;
  end

  // Datapath registers: bit buffer, run state, znz/nz output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_en          <= 1'b0;
      r_last_loaded <= 1'b0;
      r_buf         <= '0;
      r_cnt         <= '0;
      r_run         <= '0;
      r_znz         <= '0;
      r_znz_last    <= 1'b0;
      r_znz_vld     <= 1'b0;
      r_nz          <= '0;
      r_nz_vld      <= 1'b0;
    end else begin
      r_en  <= 1'b1;
      r_buf <= w_buf_nxt;
      r_cnt <= w_cnt_nxt;
      r_run <= w_run_nxt;
      if (r_state == RUN)   r_last_loaded <= 1'b0;
      else if (w_emit_last) r_last_loaded <= 1'b1;
      if (w_emit) begin
        r_znz      <= r_buf[BUF_W-1 -: OUT_W];
        r_znz_vld  <= 1'b1;
        r_znz_last <= w_emit_last;
      end else if (znz_rdy_i) begin
        r_znz_vld  <= 1'b0;
        r_znz_last <= 1'b0;
      end
      if (w_acc && !w_zero) begin
        r_nz     <= data_i;
        r_nz_vld <= 1'b1;
      end else if (nz_rdy_i) begin
        r_nz_vld <= 1'b0;
      end
    end
  end

  // Frame word counter and num_words output register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wcnt   <= '0;
      r_nw     <= '0;
      r_nw_vld <= 1'b0;
    end else if (w_acc && last_i) begin
      r_nw     <= r_wcnt + LOG_MAX_WORDS'(1);
      r_nw_vld <= 1'b1;
      r_wcnt   <= '0;
    end else begin
      if (w_acc)           r_wcnt   <= r_wcnt + LOG_MAX_WORDS'(1);
      if (num_words_rdy_i) r_nw_vld <= 1'b0;
    end
  end

`ifdef EBPC_ZNZ_ENC_STATS_EN
  logic [LOG_MAX_WORDS-1:0] r_zcnt;
  logic [LOG_MAX_WORDS-1:0] r_zw;

  // Zero-word counter, published alongside num_words_o
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_zcnt <= '0;
      r_zw   <= '0;
    end else if (w_acc) begin
      if (last_i) begin
        r_zw   <= r_zcnt + LOG_MAX_WORDS'(w_zero);
        r_zcnt <= '0;
      end else begin
        r_zcnt <= r_zcnt + LOG_MAX_WORDS'(w_zero);
      end
    end
  end

  assign zero_words_o = r_zw;
`endif

  assign rdy_o           = w_rdy;
  assign znz_o           = r_znz;
  assign znz_last_o      = r_znz_last;
  assign znz_vld_o       = r_znz_vld;
  assign nz_o            = r_nz;
  assign nz_vld_o        = r_nz_vld;
  assign num_words_o     = r_nw;
  assign num_words_vld_o = r_nw_vld;

endmodule

// File: tb/tb_ebpc_znz_encoder.sv
// Testbench for ebpc_znz_encoder: hand-derived frame table, backpressure and
// mid-frame reset sequences, then random back-to-back frames against a bit model.
module tb_ebpc_znz_encoder;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  data_i = '0;
  logic        last_i = 1'b0;
  logic        vld_i = 1'b0;
  logic        rdy_o;
  logic [7:0]  znz_o;
  logic        znz_last_o, znz_vld_o;
  logic        znz_rdy_i = 1'b0;
  logic [7:0]  nz_o;
  logic        nz_vld_o;
  logic        nz_rdy_i = 1'b0;
  logic [23:0] num_words_o;
  logic        num_words_vld_o;
  logic        num_words_rdy_i = 1'b0;
`ifdef EBPC_ZNZ_ENC_STATS_EN
  logic [23:0] zero_words_o;
`endif

  int unsigned checks = 0;
  int unsigned failures = 0;

  logic [8:0]  exp_znz[$];   // {last, word}
  logic [7:0]  exp_nz[$];
  logic [47:0] exp_nw[$];    // {zero words, num words}

  bit rand_mode = 1'b0;
  bit znz_hold  = 1'b0;
  bit stall_prev = 1'b0;
  logic [8:0] znz_prev = '0;

  ebpc_znz_encoder #(.DATA_W(8), .OUT_W(8), .MAX_ZRL_W(4), .LOG_MAX_WORDS(24)) dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .last_i(last_i), .vld_i(vld_i), .rdy_o(rdy_o),
    .znz_o(znz_o), .znz_last_o(znz_last_o), .znz_vld_o(znz_vld_o), .znz_rdy_i(znz_rdy_i),
    .nz_o(nz_o), .nz_vld_o(nz_vld_o), .nz_rdy_i(nz_rdy_i),
    .num_words_o(num_words_o), .num_words_vld_o(num_words_vld_o), .num_words_rdy_i(num_words_rdy_i)
`ifdef EBPC_ZNZ_ENC_STATS_EN
    , .zero_words_o(zero_words_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Output ready generation
  always @(posedge clk) begin
    #1;
    if (rand_mode) begin
      znz_rdy_i       = ($urandom_range(0, 3) != 0);
      nz_rdy_i        = ($urandom_range(0, 3) != 0);
      num_words_rdy_i = ($urandom_range(0, 3) != 0);
    end else begin
      znz_rdy_i       = !znz_hold;
      nz_rdy_i        = 1'b1;
      num_words_rdy_i = 1'b1;
    end
  end

  // Scoreboard monitor: handshakes sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_i) begin
      if (stall_prev) chk("znz_hold_stable", {znz_vld_o, znz_last_o, znz_o}, {1'b1, znz_prev});
      stall_prev = znz_vld_o && !znz_rdy_i;
      znz_prev   = {znz_last_o, znz_o};
      if (znz_vld_o && znz_rdy_i) begin
        if (exp_znz.size() == 0) chk("znz_unexpected", {znz_last_o, znz_o}, 48'hFFFF);
        else chk("znz_word", {znz_last_o, znz_o}, exp_znz.pop_front());
      end
      if (nz_vld_o && nz_rdy_i) begin
        if (exp_nz.size() == 0) chk("nz_unexpected", nz_o, 48'hFFFF);
        else chk("nz_value", nz_o, exp_nz.pop_front());
      end
      if (num_words_vld_o && num_words_rdy_i) begin
        logic [47:0] e;
        if (exp_nw.size() == 0) chk("nw_unexpected", num_words_o, 48'hFFFF_FFFF);
        else begin
          e = exp_nw.pop_front();
          chk("num_words", num_words_o, e[23:0]);
`ifdef EBPC_ZNZ_ENC_STATS_EN
          chk("zero_words", zero_words_o, e[47:24]);
`endif
        end
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Reference: symbol bit string packed MSB-first, last word holds the remainder
  function automatic void model_frame(input logic [7:0] f[$]);
    bit bq[$];
    int unsigned run = 0;
    int unsigned zeros = 0;
    logic [7:0] w;
    for (int unsigned i = 0; i < f.size(); i++) begin
      bit lst = (i == f.size() - 1);
      if (f[i] == 8'h00) begin
        zeros++;
        run++;
        if (run == 16 || lst) begin
          bq.push_back(1'b0);
          for (int b = 3; b >= 0; b--) bq.push_back(((run - 1) >> b) & 1);
          run = 0;
        end
      end else begin
        if (run > 0) begin
          bq.push_back(1'b0);
          for (int b = 3; b >= 0; b--) bq.push_back(((run - 1) >> b) & 1);
        end
        bq.push_back(1'b1);
        run = 0;
        exp_nz.push_back(f[i]);
      end
    end
    while (bq.size() >= 8) begin
      for (int b = 7; b >= 0; b--) w[b] = bq.pop_front();
      exp_znz.push_back({1'b0, w});
    end
    w = '0;
    for (int b = 7; b >= 0 && bq.size() > 0; b--) w[b] = bq.pop_front();
    exp_znz.push_back({1'b1, w});
    exp_nw.push_back({24'(zeros), 24'(f.size())});
  endfunction

  task automatic send_word(input logic [7:0] d, input logic l, input int unsigned gap);
    int unsigned t = 0;
    data_i = d; last_i = l; vld_i = 1'b1;
    @(negedge clk);
    while (!rdy_o && t < 2000) begin @(negedge clk); t++; end
    if (!rdy_o) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    vld_i = 1'b0; data_i = '0; last_i = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit gaps);
    for (int unsigned i = 0; i < f.size(); i++)
      send_word(f[i], (i == f.size() - 1), gaps ? $urandom_range(0, 3) : 0);
  endtask

  task automatic drain();
    int unsigned t = 0;
    while ((exp_znz.size() + exp_nz.size() + exp_nw.size()) != 0 && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    chk("drain_pending", exp_znz.size() + exp_nz.size() + exp_nw.size(), 0);
  endtask

  typedef struct {
    int unsigned n;
    logic [7:0]  w [17];
    int unsigned zn;
    logic [7:0]  z [2];
    logic [23:0] nw;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [7:0] fr[$];

    // hand-derived frames and their expected znz words
    for (int unsigned k = 0; k < 6; k++) begin
      for (int unsigned j = 0; j < 17; j++) tbl[k].w[j] = 8'h00;
      tbl[k].z[0] = 8'h00; tbl[k].z[1] = 8'h00;
    end
    tbl[0].n = 1;  tbl[0].w[0] = 8'h05; tbl[0].zn = 1; tbl[0].z[0] = 8'h80; tbl[0].nw = 1;
    tbl[1].n = 4;  tbl[1].w[3] = 8'h07; tbl[1].zn = 1; tbl[1].z[0] = 8'h14; tbl[1].nw = 4;
    tbl[2].n = 16;                      tbl[2].zn = 1; tbl[2].z[0] = 8'h78; tbl[2].nw = 16;
    tbl[3].n = 17;                      tbl[3].zn = 2; tbl[3].z[0] = 8'h78; tbl[3].nw = 17;
    tbl[4].n = 3;  tbl[4].w[0] = 8'h03; tbl[4].w[2] = 8'h04;
                   tbl[4].zn = 1; tbl[4].z[0] = 8'h82; tbl[4].nw = 3;
    tbl[5].n = 1;                       tbl[5].zn = 1; tbl[5].z[0] = 8'h00; tbl[5].nw = 1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_rdy", rdy_o, 0);
    chk("rst_znz_vld", znz_vld_o, 0);
    chk("rst_znz_last", znz_last_o, 0);
    chk("rst_znz", znz_o, 0);
    chk("rst_nz_vld", nz_vld_o, 0);
    chk("rst_nz", nz_o, 0);
    chk("rst_nw_vld", num_words_vld_o, 0);
    chk("rst_nw", num_words_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    for (int unsigned k = 0; k < 6; k++) begin
      int unsigned zc = 0;
      fr.delete();
      for (int unsigned j = 0; j < tbl[k].n; j++) begin
        fr.push_back(tbl[k].w[j]);
        if (tbl[k].w[j] != 0) exp_nz.push_back(tbl[k].w[j]); else zc++;
      end
      for (int unsigned j = 0; j < tbl[k].zn; j++)
        exp_znz.push_back({(j == tbl[k].zn - 1), tbl[k].z[j]});
      exp_nw.push_back({24'(zc), tbl[k].nw});
      send_frame(fr, 1'b0);
      drain();
    end

    // eight non-zero words while znz output is blocked
    znz_hold = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    fr.delete();
    for (int unsigned j = 1; j <= 8; j++) fr.push_back(8'(j));
    for (int unsigned j = 1; j <= 8; j++) exp_nz.push_back(8'(j));
    exp_znz.push_back({1'b0, 8'hFF});
    exp_znz.push_back({1'b1, 8'h00});
    exp_nw.push_back({24'd0, 24'd8});
    send_frame(fr, 1'b0);
    repeat (20) begin
      @(negedge clk);
      chk("bp_rdy_low", rdy_o, 0);
    end
    chk("bp_znz_held", {znz_vld_o, znz_last_o, znz_o}, {2'b10, 8'hFF});
    @(posedge clk); #1;
    znz_hold = 1'b0;
    drain();

    // reset in the middle of a frame discards the open run
    send_word(8'h00, 1'b0, 0);
    send_word(8'h00, 1'b0, 0);
    send_word(8'h00, 1'b0, 0);
    rst_i = 1'b1;
    @(negedge clk);
    chk("midrst_rdy", rdy_o, 0);
    chk("midrst_znz_vld", znz_vld_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    fr.delete();
    fr.push_back(8'h09);
    exp_znz.push_back({1'b1, 8'h80});
    exp_nz.push_back(8'h09);
    exp_nw.push_back({24'd0, 24'd1});
    send_frame(fr, 1'b0);
    drain();

    // random back-to-back frames with stalls on both sides
    rand_mode = 1'b1;
    for (int unsigned k = 0; k < 8; k++) begin
      int unsigned len = $urandom_range(1, 45);
      fr.delete();
      for (int unsigned j = 0; j < len; j++)
        fr.push_back(($urandom_range(0, 9) < 6) ? 8'h00 : 8'($urandom_range(1, 255)));
      model_frame(fr);
      send_frame(fr, 1'b1);
    end
    drain();
    rand_mode = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
